// File: rtl/host_command_sequencer.sv
// Command sequencer behind the wide UART I/O block: takes one packet, runs its
// command against the register file or the external DUT, and returns one response.
module host_command_sequencer #(
  parameter int WIDTH          = 4,
  parameter int NUM_REGS       = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                        masterClock,
  input  logic                        reset,
  input  logic [7:0]                  control,
  input  logic [WIDTH*8-1:0]          inputData,
  input  logic                        dataReceived,
  output logic                        clearDR,
  input  logic                        transmitting,
  output logic                        transmit,
  output logic [7:0]                  status,
  output logic [WIDTH*8-1:0]          outputData,
  output logic [WIDTH*8-1:0]          dutOperand,
  output logic                        dutStart,
  input  logic                        dutDone,
  input  logic [WIDTH*8-1:0]          dutResult,
  output logic [NUM_REGS*WIDTH*8-1:0] registers,
  output logic                        busy
);

  localparam int DW = WIDTH * 8;
  localparam int CW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_ACK, S_EXEC, S_WAIT_DUT, S_RESPOND, S_TXWAIT
  } state_t;

  state_t                     r_state, w_nextState;
  logic [7:0]                 r_control;
  logic [DW-1:0]              r_data;
  logic [CW-1:0]              r_count;
  logic                       r_transmit;
  logic [7:0]                 r_status;
  logic [DW-1:0]              r_outputData;
  logic [DW-1:0]              r_dutOperand;
  logic [NUM_REGS*DW-1:0]     r_registers;

  logic [3:0]                 w_opcode;
  logic [3:0]                 w_idx;
  logic                       w_idxValid;
  logic [DW-1:0]              w_regRead;
  logic                       w_timeout;

  assign w_opcode  = r_control[7:4];
  assign w_idx     = r_control[3:0];
  assign w_timeout = (r_count == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_idxValid = 1'b0;
    w_regRead  = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_idx == 4'(i)) begin
        w_idxValid = 1'b1;
        w_regRead  = r_registers[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge masterClock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_nextState;
  end

  // RESPOND only leaves once our own request has been taken up by the I/O block.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:     if (dataReceived) w_nextState = S_ACK;
      S_ACK:      if (!dataReceived) w_nextState = S_EXEC;
      S_EXEC:     w_nextState = (w_opcode == 4'h3) ? S_WAIT_DUT : S_RESPOND;
      S_WAIT_DUT: if (dutDone || w_timeout) w_nextState = S_RESPOND;
      S_RESPOND:  if (r_transmit && transmitting) w_nextState = S_TXWAIT;
      S_TXWAIT:   if (!transmitting) w_nextState = S_IDLE;
      default:    w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge masterClock or negedge reset) begin
    if (!reset) begin
      r_control    <= '0;
      r_data       <= '0;
      r_count      <= '0;
      r_transmit   <= 1'b0;
      r_status     <= '0;
      r_outputData <= '0;
      r_dutOperand <= '0;
      r_registers  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (dataReceived) begin
            r_control <= control;
            r_data    <= inputData;
            // Operand is loaded early so it is already valid during the start pulse.
            if (control[7:4] == 4'h3) r_dutOperand <= inputData;
          end
        end
        S_EXEC: begin
          r_count <= '0;
          case (w_opcode)
            4'h0: begin
              r_status     <= r_control;
              r_outputData <= r_data;
            end
            4'h1: begin
              if (w_idxValid) begin
                for (int i = 0; i < NUM_REGS; i++)
                  if (w_idx == 4'(i)) r_registers[i*DW +: DW] <= r_data;
                r_status     <= r_control;
                r_outputData <= r_data;
              end else begin
                r_status     <= 8'hE1;
                r_outputData <= '0;
              end
            end
            4'h2: begin
              r_status     <= w_idxValid ? r_control : 8'hE1;
              r_outputData <= w_idxValid ? w_regRead : '0;
            end
            4'h3: ;
            default: begin
              r_status     <= 8'hE0;
              r_outputData <= '0;
            end
          endcase
        end
        S_WAIT_DUT: begin
          r_count <= r_count + 1'b1;
          if (dutDone) begin
            r_status     <= r_control;
            r_outputData <= dutResult;
          end else if (w_timeout) begin
            r_status     <= 8'hE2;
            r_outputData <= '0;
          end
        end
        S_RESPOND: begin
          if (r_transmit && transmitting) r_transmit <= 1'b0;
          else if (!transmitting)         r_transmit <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign clearDR    = (r_state == S_ACK);
  assign dutStart   = (r_state == S_EXEC) && (w_opcode == 4'h3);
  assign busy       = (r_state != S_IDLE);
  assign transmit   = r_transmit;
  assign status     = r_status;
  assign outputData = r_outputData;
  assign dutOperand = r_dutOperand;
  assign registers  = r_registers;

endmodule

// File: tb/tb_host_command_sequencer.sv
// Bench for host_command_sequencer: models the UART I/O block and a simple DUT,
// checks every response through an in-order scoreboard.
module tb_host_command_sequencer;

  logic         masterClock;
  logic         reset;
  logic [7:0]   control;
  logic [31:0]  inputData;
  logic         dataReceived;
  logic         clearDR;
  logic         transmitting;
  logic         transmit;
  logic [7:0]   status;
  logic [31:0]  outputData;
  logic [31:0]  dutOperand;
  logic         dutStart;
  logic         dutDone;
  logic [31:0]  dutResult;
  logic [127:0] registers;
  logic         busy;

  host_command_sequencer #(
    .WIDTH(4), .NUM_REGS(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .masterClock(masterClock), .reset(reset), .control(control),
    .inputData(inputData), .dataReceived(dataReceived), .clearDR(clearDR),
    .transmitting(transmitting), .transmit(transmit), .status(status),
    .outputData(outputData), .dutOperand(dutOperand), .dutStart(dutStart),
    .dutDone(dutDone), .dutResult(dutResult), .registers(registers), .busy(busy)
  );

  typedef struct {
    logic [7:0]  st;
    logic [31:0] dt;
  } resp_t;

  typedef struct {
    logic [7:0]  ctrl;
    logic [31:0] data;
    logic [7:0]  expSt;
    logic [31:0] expData;
  } vec_t;

  resp_t       sbQ[$];
  int          nChecks = 0;
  int          nPass = 0;
  int          respCount = 0;
  int          packetsSent = 0;
  int          clearRises = 0;
  int          startPulses = 0;
  int          dutDelay = 0;
  logic [31:0] dutRes = '0;
  logic [31:0] operandSeen = '0;

  initial masterClock = 1'b0;
  always #5 masterClock = ~masterClock;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Counts clearDR rising edges and cycles with dutStart high.
  initial begin
    logic prevClear;
    prevClear = 1'b0;
    forever begin
      @(negedge masterClock);
      if (clearDR === 1'b1 && !prevClear) clearRises++;
      prevClear = (clearDR === 1'b1);
      if (dutStart === 1'b1) startPulses++;
    end
  end

  // DUT model: answers dutDone dutDelay cycles after the start pulse (never if 0).
  initial begin
    dutDone = 1'b0;
    dutResult = '0;
    forever begin
      @(negedge masterClock);
      if (dutStart === 1'b1) begin
        operandSeen = dutOperand;
        if (dutDelay > 0) begin
          repeat (dutDelay) @(negedge masterClock);
          dutDone = 1'b1;
          dutResult = dutRes;
          @(negedge masterClock);
          dutDone = 1'b0;
          dutResult = '0;
        end
      end
    end
  end

  // I/O block transmit side: captures each response and scores it.
  initial begin
    logic [7:0]  capSt;
    logic [31:0] capDt;
    resp_t       e;
    transmitting = 1'b0;
    forever begin
      @(negedge masterClock);
      if (transmit === 1'b1 && !transmitting) begin
        capSt = status;
        capDt = outputData;
        checkOutput("sbNotEmpty", 128'(sbQ.size() != 0), 128'd1);
        if (sbQ.size() != 0) begin
          e = sbQ.pop_front();
          checkOutput("respStatus", 128'(capSt), 128'(e.st));
          checkOutput("respData", 128'(capDt), 128'(e.dt));
        end
        respCount++;
        transmitting = 1'b1;
        repeat (3) @(negedge masterClock);
        checkOutput("txDropped", 128'(transmit), 128'd0);
        checkOutput("respHeld", 128'({status, outputData}), 128'({capSt, capDt}));
        transmitting = 1'b0;
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] c, input logic [31:0] d,
                               input logic [7:0] es, input logic [31:0] ed,
                               input bit expectResp);
    int    cyc;
    resp_t r;
    if (expectResp) begin
      r.st = es;
      r.dt = ed;
      sbQ.push_back(r);
    end
    @(negedge masterClock);
    control = c;
    inputData = d;
    dataReceived = 1'b1;
    packetsSent++;
    cyc = 0;
    while (clearDR !== 1'b1 && cyc < 200) begin
      @(negedge masterClock);
      cyc++;
    end
    checkOutput("clearDRseen", 128'(clearDR), 128'd1);
    dataReceived = 1'b0;
    control = 8'hFF;
    inputData = 32'hFFFF_FFFF;
  endtask

  task automatic waitResponses(input int target);
    int cyc;
    cyc = 0;
    while (respCount < target && cyc < 300) begin
      @(negedge masterClock);
      cyc++;
    end
    checkOutput("respArrived", 128'(respCount >= target), 128'd1);
  endtask

  vec_t vecs[9];

  initial begin
    int startSnap;
    int respSnap;
    int cyc;

    vecs[0] = '{8'h12, 32'hDEADBEEF, 8'h12, 32'hDEADBEEF};
    vecs[1] = '{8'h22, 32'h00000000, 8'h22, 32'hDEADBEEF};
    vecs[2] = '{8'h07, 32'h01020304, 8'h07, 32'h01020304};
    vecs[3] = '{8'h5A, 32'h11111111, 8'hE0, 32'h00000000};
    vecs[4] = '{8'h24, 32'h22222222, 8'hE1, 32'h00000000};
    vecs[5] = '{8'h14, 32'h33333333, 8'hE1, 32'h00000000};
    vecs[6] = '{8'h10, 32'hCAFEF00D, 8'h10, 32'hCAFEF00D};
    vecs[7] = '{8'h20, 32'h00000000, 8'h20, 32'hCAFEF00D};
    vecs[8] = '{8'hF3, 32'h44444444, 8'hE0, 32'h00000000};

    reset = 1'b0;
    control = '0;
    inputData = '0;
    dataReceived = 1'b0;
    repeat (3) @(negedge masterClock);
    checkOutput("rstOutputs", 128'({busy, clearDR, transmit, dutStart, status}), 128'd0);
    checkOutput("rstData", 128'({outputData, dutOperand}), 128'd0);
    checkOutput("rstRegs", registers, 128'd0);
    reset = 1'b1;

    $display("[TB] table-driven commands");
    for (int i = 0; i < $size(vecs); i++) begin
      applyStimulus(vecs[i].ctrl, vecs[i].data, vecs[i].expSt, vecs[i].expData, 1'b1);
      waitResponses(respCount + 1);
    end
    checkOutput("regsAfterTable", registers, {32'h0, 32'hDEADBEEF, 32'h0, 32'hCAFEF00D});

    $display("[TB] RUN with DUT answering after 5 cycles");
    dutDelay = 5;
    dutRes = 32'h00000064;
    startSnap = startPulses;
    applyStimulus(8'h30, 32'h0000000A, 8'h30, 32'h00000064, 1'b1);
    waitResponses(respCount + 1);
    checkOutput("runStartPulses", 128'(startPulses - startSnap), 128'd1);
    checkOutput("runOperandAtStart", 128'(operandSeen), 128'h0000000A);
    checkOutput("runOperandHeld", 128'(dutOperand), 128'h0000000A);

    $display("[TB] RUN with DUT done on the last allowed cycle");
    dutDelay = 16;
    dutRes = 32'h0BADF00D;
    applyStimulus(8'h3C, 32'h00000007, 8'h3C, 32'h0BADF00D, 1'b1);
    waitResponses(respCount + 1);

    $display("[TB] RUN with DUT done one cycle too late");
    dutDelay = 17;
    dutRes = 32'h55555555;
    applyStimulus(8'h30, 32'h00000008, 8'hE2, 32'h00000000, 1'b1);
    waitResponses(respCount + 1);

    $display("[TB] RUN with no DUT answer, then PING");
    dutDelay = 0;
    applyStimulus(8'h30, 32'h00000005, 8'hE2, 32'h00000000, 1'b1);
    waitResponses(respCount + 1);
    applyStimulus(8'h01, 32'hA5A5A5A5, 8'h01, 32'hA5A5A5A5, 1'b1);
    waitResponses(respCount + 1);

    $display("[TB] packet pending while busy");
    respSnap = respCount;
    applyStimulus(8'h07, 32'hAAAA5555, 8'h07, 32'hAAAA5555, 1'b1);
    applyStimulus(8'h11, 32'h12345678, 8'h11, 32'h12345678, 1'b1);
    waitResponses(respSnap + 2);
    checkOutput("regsBeforeReset", registers,
                {32'h0, 32'hDEADBEEF, 32'h12345678, 32'hCAFEF00D});

    $display("[TB] reset during WAIT_DUT");
    dutDelay = 0;
    startSnap = startPulses;
    applyStimulus(8'h30, 32'h00000099, 8'h00, 32'h0, 1'b0);
    cyc = 0;
    while (startPulses == startSnap && cyc < 50) begin
      @(negedge masterClock);
      cyc++;
    end
    checkOutput("midResetStarted", 128'(startPulses - startSnap), 128'd1);
    repeat (3) @(negedge masterClock);
    respSnap = respCount;
    reset = 1'b0;
    #1;
    checkOutput("midRstOutputs", 128'({busy, clearDR, transmit, dutStart, status}), 128'd0);
    checkOutput("midRstData", 128'({outputData, dutOperand}), 128'd0);
    checkOutput("midRstRegs", registers, 128'd0);
    @(negedge masterClock);
    reset = 1'b1;
    repeat (30) @(negedge masterClock);
    checkOutput("noRespAfterReset", 128'(respCount), 128'(respSnap));
    applyStimulus(8'h07, 32'h01020304, 8'h07, 32'h01020304, 1'b1);
    waitResponses(respCount + 1);
    checkOutput("regsAfterResetPing", registers, 128'd0);

    repeat (10) @(negedge masterClock);
    checkOutput("sbEmpty", 128'(sbQ.size()), 128'd0);
    checkOutput("clearDRpulses", 128'(clearRises), 128'(packetsSent));
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
